blink_ctrl: RTL and testbench
=============================

BLINK_CTRL -- requirements
Module: blink_ctrl

Interface
REQ-001 Parameter WIDTH, default 26, counter and period width in bits.
REQ-002 Parameter DEFAULT_PERIOD, default 50_000_000, period loaded at reset (1 s at 50 MHz).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 START  input  1  level-sampled request to run or resume.
REQ-006 STOP  input  1  level-sampled request to pause, or abort when already paused.
REQ-007 LD_PERIOD  input  1  one-cycle strobe to capture PERIOD_IN.
REQ-008 PERIOD_IN  input  WIDTH  requested period in CLK cycles.
REQ-009 COUNT  output  WIDTH  current count value.
REQ-010 LED_OUT  output  1  50% duty blink output.
REQ-011 TICK  output  1  one-cycle pulse per completed period.
REQ-012 BUSY  output  1  high in RUN or PAUSE.
REQ-013 TOGGLE_OUT  output  1  divide-by-two of TICK (present only with BLINK_CTRL_TOGGLE_EN).

Function
REQ-014 FSM states IDLE, RUN, PAUSE; BUSY = (state != IDLE).
REQ-015 IDLE: START -> RUN; COUNT held at 0.
REQ-016 RUN: COUNT increments by 1 per cycle; STOP -> PAUSE with COUNT frozen at its value that cycle.
REQ-017 PAUSE: START -> RUN resuming from the frozen COUNT; STOP -> IDLE with COUNT cleared to 0.
REQ-018 START and STOP asserted in the same cycle: STOP takes priority.
REQ-019 Wrap: in RUN when COUNT == period-1, the next COUNT is 0 and TICK is 1 for exactly the following cycle.
REQ-020 TICK is registered: 1-cycle latency after the wrap edge, and never asserted outside RUN.
REQ-021 LED_OUT = 1 when COUNT >= (period >> 1), else 0; derived from registered COUNT and period with no extra latency.
REQ-022 LED_OUT is 0 in IDLE.
REQ-023 LD_PERIOD with PERIOD_IN < 2 is ignored; the period is unchanged.
REQ-024 LD_PERIOD in IDLE or PAUSE updates the active period on the next cycle.
REQ-025 PAUSE reload with COUNT >= new period: COUNT clears to 0 on resume.
REQ-026 LD_PERIOD in RUN writes a shadow register; the active period takes the shadow value at the next wrap.
REQ-027 A later LD_PERIOD before that wrap overwrites the shadow value.
REQ-028 Period arithmetic is WIDTH-bit unsigned; PERIOD_IN up to 2^WIDTH-1 is legal; no overflow past period-1.

Reset
REQ-029 RST has priority over all inputs.
REQ-030 Reset values: state IDLE, COUNT 0, TICK 0, LED_OUT 0, BUSY 0, TOGGLE_OUT 0.
REQ-031 Reset values: active and shadow period both DEFAULT_PERIOD.
REQ-032 RST asserted mid-RUN: reset state on the next edge, with no TICK emitted.

Configuration
REQ-033 Macro BLINK_CTRL_TOGGLE_EN defined: TOGGLE_OUT exists, flips on every TICK cycle, holds otherwise, and clears to 0 on RST or on the PAUSE->IDLE abort.
REQ-034 Macro BLINK_CTRL_TOGGLE_EN undefined: TOGGLE_OUT port and its flop are absent; all other behaviour is identical.

Structure
REQ-035 Shared package blink_pkg holds the state enum (IDLE, RUN, PAUSE), WIDTH_DEFAULT = 26 and PERIOD_1S = 50_000_000.
REQ-036 Sub-module period_counter holds the WIDTH-bit counter with enable, synchronous clear and terminal-count compare.
REQ-037 blink_ctrl contains the FSM, period and shadow registers, LED compare, TICK and toggle logic.

Verification (WIDTH=26, DEFAULT_PERIOD=10 unless stated)
REQ-038 RST, START 1 cycle -> COUNT 0..9 repeating; TICK high 1 cycle after each 9->0; LED_OUT high for COUNT 5..9.
REQ-039 STOP at COUNT=4, hold 3 cycles, then START -> COUNT stays 4 while paused, then resumes 5; BUSY stays 1.
REQ-040 STOP+START in same cycle in RUN -> PAUSE; second STOP -> IDLE, COUNT 0, LED_OUT 0, BUSY 0.
REQ-041 LD_PERIOD=4 at COUNT=2 in RUN -> counts to 9, wraps, then 0..3 repeating; LD_PERIOD=1 -> ignored.
REQ-042 RST asserted at COUNT=9 in RUN -> next cycle COUNT 0, TICK 0, IDLE.
REQ-043 BLINK_CTRL_TOGGLE_EN, DEFAULT_PERIOD=50_000_000 -> TOGGLE_OUT 0.5 Hz, LED_OUT 1 Hz at 50% duty.

Source files
------------

// File: rtl/blink_ctrl_pkg.sv
// Shared types and constants for the blink controller.
// Included by blink_ctrl, its interface and period_counter.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    localparam int unsigned WIDTH_DEFAULT = 26;
    localparam int unsigned PERIOD_1S     = 50_000_000;

endpackage

// File: rtl/blink_ctrl_if.sv
// Control/status bundle between a host and blink_ctrl.
// master drives the requests, slave returns count and status.
interface blink_ctrl_if
    import blink_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);

    logic             START;
    logic             STOP;
    logic             LD_PERIOD;
    logic [WIDTH-1:0] PERIOD_IN;
    logic [WIDTH-1:0] COUNT;
    logic             LED_OUT;
    logic             TICK;
    logic             BUSY;

    modport master (
        output START,
        output STOP,
        output LD_PERIOD,
        output PERIOD_IN,
        input  COUNT,
        input  LED_OUT,
        input  TICK,
        input  BUSY
    );

    modport slave (
        input  START,
        input  STOP,
        input  LD_PERIOD,
        input  PERIOD_IN,
        output COUNT,
        output LED_OUT,
        output TICK,
        output BUSY
    );

endinterface

// File: rtl/blink_ctrl_period_counter.sv
// Free-running period counter with enable, sync clear and
// terminal-count flag; wraps to 0 after reaching last.
module period_counter
    import blink_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    // >= rather than == so a stale count can never run past last
    assign tc = (count >= last);

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/blink_ctrl.sv
// Blink controller: IDLE/RUN/PAUSE FSM, shadowed period, LED, TICK.
// Optional TOGGLE_OUT divider when BLINK_CTRL_TOGGLE_EN is defined.
module blink_ctrl
    import blink_pkg::*;
#(
    parameter int unsigned      WIDTH          = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] DEFAULT_PERIOD = WIDTH'(PERIOD_1S)
) (
    input  logic        CLK,
    input  logic        RST,
`ifdef BLINK_CTRL_TOGGLE_EN
    output logic        TOGGLE_OUT,
`endif
    blink_ctrl_if.slave bus
);

    state_t           st_q;
    logic [WIDTH-1:0] per_q;
    logic [WIDTH-1:0] shd_q;
    logic [WIDTH-1:0] per_nx;
    logic [WIDTH-1:0] shd_nx;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] last;
    logic             tc;
    logic             tick_q;
    logic             busy_q;
    logic             ld_ok;
    logic             cnt_en;
    logic             wrap;
    logic             abort;
    logic             clr;

    always_comb begin
        ld_ok  = bus.LD_PERIOD && (bus.PERIOD_IN >= WIDTH'(2));
        cnt_en = (st_q == RUN) && !bus.STOP;
        wrap   = cnt_en && tc;
        abort  = (st_q == PAUSE) && bus.STOP;
        shd_nx = ld_ok ? bus.PERIOD_IN : shd_q;
        per_nx = per_q;
        // While running, a new period waits in the shadow for the wrap
        if (st_q != RUN && ld_ok) begin
            per_nx = bus.PERIOD_IN;
        end else if (wrap) begin
            per_nx = shd_nx;
        end
        clr = (st_q == IDLE) || abort ||
              ((st_q == PAUSE) && bus.START &&
               (count >= per_nx));
    end

    assign last = per_q - WIDTH'(1);

    period_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (clr),
        .en    (cnt_en),
        .last  (last),
        .count (count),
        .tc    (tc)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            st_q   <= IDLE;
            busy_q <= 1'b0;
            tick_q <= 1'b0;
            per_q  <= DEFAULT_PERIOD;
            shd_q  <= DEFAULT_PERIOD;
        end else begin
            per_q  <= per_nx;
            shd_q  <= shd_nx;
            tick_q <= wrap;
            unique case (1'b1)
                (st_q == IDLE): begin
                    if (bus.START && !bus.STOP) begin
                        st_q   <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                (st_q == RUN): begin
                    if (bus.STOP) begin
                        st_q <= PAUSE;
                    end
                end
                (st_q == PAUSE): begin
                    if (bus.STOP) begin
                        st_q   <= IDLE;
                        busy_q <= 1'b0;
                    end else if (bus.START) begin
                        st_q <= RUN;
                    end
                end
                default: begin
                    st_q   <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.COUNT   = count;
    assign bus.TICK    = tick_q;
    assign bus.BUSY    = busy_q;
    assign bus.LED_OUT = busy_q && (count >= (per_q >> 1));

`ifdef BLINK_CTRL_TOGGLE_EN
    logic tog_q;

    always_ff @(posedge CLK) begin
        if (RST || abort) begin
            tog_q <= 1'b0;
        end else if (tick_q) begin
            tog_q <= ~tog_q;
        end
    end

    assign TOGGLE_OUT = tog_q;
`endif

endmodule

// File: tb/tb_blink_ctrl.sv
// Directed bench for blink_ctrl (WIDTH=26, DEFAULT_PERIOD=10)
// with a per-cycle behavioural model and literal spot checks.
module tb_blink_ctrl;

    localparam int W = 26;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    blink_ctrl_if #(.WIDTH(W)) bus ();

`ifdef BLINK_CTRL_TOGGLE_EN
    logic TOGGLE_OUT;
`endif

    blink_ctrl #(
        .WIDTH          (W),
        .DEFAULT_PERIOD (26'd10)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
`ifdef BLINK_CTRL_TOGGLE_EN
        .TOGGLE_OUT (TOGGLE_OUT),
`endif
        .bus        (bus)
    );

    int tests  = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    // Model: mode 0 idle, 1 run, 2 pause
    int m_mode = 0;
    int m_cnt  = 0;
    int m_per  = 10;
    int m_shd  = 10;
    bit m_tick = 1'b0;
    bit m_tog  = 1'b0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin : model
        bit ldok;
        bit tprev;
        int p;
        if (RST) begin
            m_mode = 0;
            m_cnt  = 0;
            m_per  = 10;
            m_shd  = 10;
            m_tick = 1'b0;
            m_tog  = 1'b0;
        end else begin
            p     = int'(bus.PERIOD_IN);
            ldok  = bus.LD_PERIOD && (p >= 2);
            tprev = m_tick;
            m_tick = 1'b0;
            if (tprev) m_tog = !m_tog;
            case (m_mode)
                0: begin
                    if (ldok) begin
                        m_per = p;
                        m_shd = p;
                    end
                    if (bus.START && !bus.STOP) m_mode = 1;
                end
                1: begin
                    if (ldok) m_shd = p;
                    if (bus.STOP) begin
                        m_mode = 2;
                    end else if (m_cnt == m_per - 1) begin
                        m_cnt  = 0;
                        m_tick = 1'b1;
                        m_per  = m_shd;
                    end else begin
                        m_cnt++;
                    end
                end
                default: begin
                    if (ldok) begin
                        m_per = p;
                        m_shd = p;
                    end
                    if (bus.STOP) begin
                        m_mode = 0;
                        m_cnt  = 0;
                        m_tog  = 1'b0;
                    end else if (bus.START) begin
                        m_mode = 1;
                        if (m_cnt >= m_per) m_cnt = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("count", 32'(bus.COUNT), m_cnt);
            check("tick", 32'(bus.TICK), 32'(m_tick));
            check("busy", 32'(bus.BUSY), 32'(m_mode != 0));
            check("led", 32'(bus.LED_OUT),
                  32'(m_mode != 0 && m_cnt >= (m_per >> 1)));
`ifdef BLINK_CTRL_TOGGLE_EN
            check("toggle", 32'(TOGGLE_OUT), 32'(m_tog));
`endif
        end
    end

    task automatic step(input bit st, input bit sp,
                        input bit ld, input int pin);
        bus.START     = st;
        bus.STOP      = sp;
        bus.LD_PERIOD = ld;
        bus.PERIOD_IN = W'(pin);
        @(posedge CLK);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        bus.START     = 1'b0;
        bus.STOP      = 1'b0;
        bus.LD_PERIOD = 1'b0;
        bus.PERIOD_IN = '0;
        RST = 1'b1;
        idle(2);
        chk_en = 1'b1;
        RST = 1'b0;
        check("rst_count", 32'(bus.COUNT), 0);
        check("rst_busy", 32'(bus.BUSY), 0);
        check("rst_led", 32'(bus.LED_OUT), 0);
        check("rst_tick", 32'(bus.TICK), 0);

        // Basic run with period 10
        step(1'b1, 1'b0, 1'b0, 0);
        check("run0_count", 32'(bus.COUNT), 0);
        check("run0_busy", 32'(bus.BUSY), 1);
        for (int n = 1; n <= 24; n++) begin
            idle(1);
            if (n == 4) check("led_lo4", 32'(bus.LED_OUT), 0);
            if (n == 5) check("led_hi5", 32'(bus.LED_OUT), 1);
            if (n == 10) begin
                check("wrap_count", 32'(bus.COUNT), 0);
                check("wrap_tick", 32'(bus.TICK), 1);
            end
            if (n == 11) check("tick_once", 32'(bus.TICK), 0);
        end

        // Pause at 4, hold, resume
        step(1'b0, 1'b1, 1'b0, 0);
        idle(3);
        check("pause_count", 32'(bus.COUNT), 4);
        check("pause_busy", 32'(bus.BUSY), 1);
        step(1'b1, 1'b0, 1'b0, 0);
        check("resume_count", 32'(bus.COUNT), 4);
        idle(1);
        check("resume_next", 32'(bus.COUNT), 5);

        // START+STOP together pauses, second STOP aborts
        step(1'b1, 1'b1, 1'b0, 0);
        idle(1);
        check("both_count", 32'(bus.COUNT), 5);
        check("both_busy", 32'(bus.BUSY), 1);
        step(1'b0, 1'b1, 1'b0, 0);
        check("abort_count", 32'(bus.COUNT), 0);
        check("abort_busy", 32'(bus.BUSY), 0);
        check("abort_led", 32'(bus.LED_OUT), 0);

        // Shadow reload to 4 in RUN, then ignored load of 1
        step(1'b1, 1'b0, 1'b0, 0);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 4);
        idle(6);
        check("shadow_9", 32'(bus.COUNT), 9);
        idle(1);
        check("shadow_wrap", 32'(bus.TICK), 1);
        idle(4);
        check("p4_count", 32'(bus.COUNT), 0);
        check("p4_tick", 32'(bus.TICK), 1);
        step(1'b0, 1'b0, 1'b1, 1);
        idle(10);
        check("ign_count", 32'(bus.COUNT), 3);
        idle(1);
        check("ign_tick", 32'(bus.TICK), 1);

        // Pause reload below current count clears on resume
        idle(3);
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 2);
        step(1'b1, 1'b0, 1'b0, 0);
        check("reload_clr", 32'(bus.COUNT), 0);
        idle(1);
        check("p2_led", 32'(bus.LED_OUT), 1);
        idle(1);
        check("p2_tick", 32'(bus.TICK), 1);
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);

        // Later RUN load overwrites the shadow
        step(1'b0, 1'b0, 1'b1, 10);
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 6);
        step(1'b0, 1'b0, 1'b1, 3);
        idle(8);
        check("ovr_wrap", 32'(bus.TICK), 1);
        idle(3);
        check("p3_count", 32'(bus.COUNT), 0);
        check("p3_tick", 32'(bus.TICK), 1);

        // Maximum period
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, (1 << W) - 1);
        step(1'b1, 1'b0, 1'b0, 0);
        idle(5);
        check("max_count", 32'(bus.COUNT), 5);
        check("max_led", 32'(bus.LED_OUT), 0);

        // Reset at COUNT 9
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 10);
        step(1'b1, 1'b0, 1'b0, 0);
        idle(9);
        check("pre_rst", 32'(bus.COUNT), 9);
        RST = 1'b1;
        idle(1);
        RST = 1'b0;
        check("mid_rst_count", 32'(bus.COUNT), 0);
        check("mid_rst_tick", 32'(bus.TICK), 0);
        check("mid_rst_busy", 32'(bus.BUSY), 0);
        idle(3);
        check("post_rst", 32'(bus.COUNT), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
